// File: rtl/btn_input_rx.sv
// Push-button receiver: synchronise, debounce and classify N buttons into press,
// release, long-press and auto-repeat pulses; buttons 0/1 step a 3-bit position index.
module btn_input_rx #(
    parameter int N_BTN        = 2,
    parameter int DEBOUNCE_CYC = 240000,
    parameter int LONG_CYC     = 12000000,
    parameter int REPEAT_CYC   = 2400000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [2:0]       sel
);

    localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam int REP_W  = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_CYC - 1);
    localparam logic              IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {RELEASED, PRESSED, HELD} hold_state_e;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] samp;

    // Sync flops idle at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= {N_BTN{IDLE_PIN}};
            sync2 <= {N_BTN{IDLE_PIN}};
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign samp = sync2 ^ {N_BTN{IDLE_PIN}};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [DEB_W-1:0]  deb_cnt;
        logic              level;
        logic              press_now;
        logic              release_now;
        hold_state_e       state;
        hold_state_e       state_nx;
        logic [HOLD_W-1:0] hold_cnt;
        logic [HOLD_W-1:0] hold_nx;
        logic [REP_W-1:0]  rep_cnt;
        logic [REP_W-1:0]  rep_nx;
        logic              long_nx;
        logic              repeat_nx;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              repeat_q;

        assign press_now   = (samp[i] != level) && (deb_cnt == DEB_MAX) && samp[i];
        assign release_now = (samp[i] != level) && (deb_cnt == DEB_MAX) && !samp[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt <= '0;
                level   <= 1'b0;
            end else if (samp[i] == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_MAX) begin
                deb_cnt <= '0;
                level   <= samp[i];
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end

        // A release on the terminal-count cycle suppresses the long/repeat pulse.
        always_comb begin
            state_nx  = state;
            hold_nx   = hold_cnt;
            rep_nx    = rep_cnt;
            long_nx   = 1'b0;
            repeat_nx = 1'b0;
            case (state)
                RELEASED: begin
                    if (press_now) begin
                        state_nx = PRESSED;
                        hold_nx  = '0;
                    end
                end
                PRESSED: begin
                    if (release_now) begin
                        state_nx = RELEASED;
                    end else if (hold_cnt == HOLD_MAX) begin
                        long_nx  = 1'b1;
                        state_nx = HELD;
                        rep_nx   = '0;
                    end else begin
                        hold_nx = hold_cnt + HOLD_W'(1);
                    end
                end
                HELD: begin
                    if (release_now) begin
                        state_nx = RELEASED;
                    end else if (rep_cnt == REP_MAX) begin
                        repeat_nx = 1'b1;
                        rep_nx    = '0;
                    end else begin
                        rep_nx = rep_cnt + REP_W'(1);
                    end
                end
                default: state_nx = RELEASED;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= RELEASED;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_nx;
                hold_cnt  <= hold_nx;
                rep_cnt   <= rep_nx;
                press_q   <= press_now;
                release_q <= release_now;
                long_q    <= long_nx;
                repeat_q  <= repeat_nx;
            end
        end

        assign btn_level[i]     = level;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
        assign repeat_pulse[i]  = repeat_q;
    end

    logic step_up;
    logic step_dn;
    logic [2:0] sel_q;

    assign step_up = press_pulse[0] | repeat_pulse[0];
    assign step_dn = press_pulse[1] | repeat_pulse[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 3'd0;
        end else if (step_up && !step_dn) begin
            sel_q <= sel_q + 3'd1;
        end else if (step_dn && !step_up) begin
            sel_q <= sel_q - 3'd1;
        end
    end

    assign sel = sel_q;

endmodule

// File: tb/tb_btn_input_rx.sv
// Scoreboard bench for btn_input_rx: expected events (cycle, kind, button) are queued
// as stimulus is driven and compared against pulses seen on the outputs.
module tb_btn_input_rx;

    localparam int N_BTN = 2;
    localparam int DEB   = 4;
    localparam int LONG  = 20;
    localparam int REP   = 5;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] repeat_pulse;
    logic [2:0]       sel;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];
    int obs_q[$];
    logic [2:0] exp_sel;

    btn_input_rx #(
        .N_BTN(N_BTN), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG),
        .REPEAT_CYC(REP), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .sel(sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event code = cycle*16 + kind*4 + button; kind order matches the push order in tests.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int b = 0; b < N_BTN; b++) if (press_pulse[b])   obs_q.push_back(cyc*16 + K_PRESS*4 + b);
            for (int b = 0; b < N_BTN; b++) if (release_pulse[b]) obs_q.push_back(cyc*16 + K_RELEASE*4 + b);
            for (int b = 0; b < N_BTN; b++) if (long_pulse[b])    obs_q.push_back(cyc*16 + K_LONG*4 + b);
            for (int b = 0; b < N_BTN; b++) if (repeat_pulse[b])  obs_q.push_back(cyc*16 + K_REPEAT*4 + b);
        end
    end

    task automatic goto_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int c, input int kind, input int b);
        exp_q.push_back(c*16 + kind*4 + b);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== '0) begin
            failures++;
            $display("FAIL reset_pulses actual=%b required=0",
                     {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
        checks++;
        if (sel !== 3'd0) begin
            failures++;
            $display("FAIL reset_sel actual=%0d required=0", sel);
        end
        rst_n = 1'b1;
        exp_sel = 3'd0;
        exp_q.delete();
        obs_q.delete();
        goto_cyc(cyc + 50);
        @(negedge clk);
        checks++;
        if (btn_level !== 2'b00) begin
            failures++;
            $display("FAIL idle_level actual=%b required=00", btn_level);
        end
        checks++;
        if (sel !== 3'd0) begin
            failures++;
            $display("FAIL idle_sel actual=%0d required=0", sel);
        end
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL idle_events actual=%0d required=0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_long_repeat();
        int c0;
        int e;
        int o;
        int n;
        goto_cyc(cyc + 1);
        c0 = cyc;
        btn_raw = 2'b01;
        push_ev(c0 + 6,  K_PRESS,  1);
        push_ev(c0 + 26, K_LONG,   1);
        push_ev(c0 + 31, K_REPEAT, 1);
        push_ev(c0 + 36, K_REPEAT, 1);
        push_ev(c0 + 41, K_REPEAT, 1);
        push_ev(c0 + 46, K_RELEASE, 1);
        goto_cyc(c0 + 6);
        @(negedge clk);
        checks++;
        if (sel !== exp_sel) begin
            failures++;
            $display("FAIL lr_sel_before actual=%0d required=%0d", sel, exp_sel);
        end
        exp_sel = exp_sel - 3'd1;
        goto_cyc(c0 + 7);
        @(negedge clk);
        checks++;
        if (sel !== exp_sel) begin
            failures++;
            $display("FAIL lr_sel_press actual=%0d required=%0d", sel, exp_sel);
        end
        goto_cyc(c0 + 27);
        @(negedge clk);
        checks++;
        if (sel !== exp_sel) begin
            failures++;
            $display("FAIL lr_sel_long actual=%0d required=%0d", sel, exp_sel);
        end
        for (int k = 0; k < 3; k++) begin
            exp_sel = exp_sel - 3'd1;
            if (k == 2) begin
                goto_cyc(c0 + 40);
                btn_raw = 2'b11;
            end
            goto_cyc(c0 + 32 + 5*k);
            @(negedge clk);
            checks++;
            if (sel !== exp_sel) begin
                failures++;
                $display("FAIL lr_sel_repeat%0d actual=%0d required=%0d", k, sel, exp_sel);
            end
        end
        goto_cyc(c0 + 60);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (i < exp_q.size()) ? exp_q[i] : -1;
            o = (i < obs_q.size()) ? obs_q[i] : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lr_event%0d actual=%0d required=%0d (cyc*16+kind*4+btn)", i, o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_single_press();
        int c0;
        int e;
        int o;
        int n;
        goto_cyc(cyc + 1);
        c0 = cyc;
        btn_raw = 2'b10;
        push_ev(c0 + 6, K_PRESS, 0);
        goto_cyc(c0 + 6);
        @(negedge clk);
        checks++;
        if (btn_level !== 2'b01 || sel !== exp_sel) begin
            failures++;
            $display("FAIL sp_level_sel actual=%b/%0d required=01/%0d", btn_level, sel, exp_sel);
        end
        exp_sel = exp_sel + 3'd1;
        goto_cyc(c0 + 7);
        @(negedge clk);
        checks++;
        if (sel !== exp_sel) begin
            failures++;
            $display("FAIL sp_sel actual=%0d required=%0d", sel, exp_sel);
        end
        goto_cyc(c0 + 10);
        btn_raw = 2'b11;
        push_ev(c0 + 16, K_RELEASE, 0);
        goto_cyc(c0 + 30);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (i < exp_q.size()) ? exp_q[i] : -1;
            o = (i < obs_q.size()) ? obs_q[i] : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sp_event%0d actual=%0d required=%0d (cyc*16+kind*4+btn)", i, o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_bounce();
        int c0;
        goto_cyc(cyc + 1);
        c0 = cyc;
        btn_raw = 2'b10;
        goto_cyc(c0 + 3);
        btn_raw = 2'b11;
        goto_cyc(c0 + 4);
        btn_raw = 2'b10;
        goto_cyc(c0 + 7);
        btn_raw = 2'b11;
        goto_cyc(c0 + 25);
        @(negedge clk);
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL bounce_events actual=%0d required=0", obs_q.size());
        end
        checks++;
        if (sel !== exp_sel || btn_level !== 2'b00) begin
            failures++;
            $display("FAIL bounce_state actual=%0d/%b required=%0d/00", sel, btn_level, exp_sel);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_both();
        int c0;
        int e;
        int o;
        int n;
        goto_cyc(cyc + 1);
        c0 = cyc;
        btn_raw = 2'b00;
        push_ev(c0 + 6, K_PRESS, 0);
        push_ev(c0 + 6, K_PRESS, 1);
        goto_cyc(c0 + 6);
        @(negedge clk);
        checks++;
        if (press_pulse !== 2'b11) begin
            failures++;
            $display("FAIL both_press actual=%b required=11", press_pulse);
        end
        goto_cyc(c0 + 7);
        @(negedge clk);
        checks++;
        if (sel !== exp_sel) begin
            failures++;
            $display("FAIL both_sel actual=%0d required=%0d", sel, exp_sel);
        end
        goto_cyc(c0 + 10);
        btn_raw = 2'b11;
        push_ev(c0 + 16, K_RELEASE, 0);
        push_ev(c0 + 16, K_RELEASE, 1);
        goto_cyc(c0 + 30);
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (i < exp_q.size()) ? exp_q[i] : -1;
            o = (i < obs_q.size()) ? obs_q[i] : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL both_event%0d actual=%0d required=%0d (cyc*16+kind*4+btn)", i, o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_hold();
        int c0;
        int r0;
        int e;
        int o;
        int n;
        goto_cyc(cyc + 1);
        c0 = cyc;
        btn_raw = 2'b10;
        push_ev(c0 + 6,  K_PRESS, 0);
        push_ev(c0 + 26, K_LONG,  0);
        goto_cyc(c0 + 28);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, sel} !== '0) begin
            failures++;
            $display("FAIL midhold_reset actual=%b required=0",
                     {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, sel});
        end
        goto_cyc(c0 + 30);
        rst_n = 1'b1;
        r0 = cyc;
        exp_sel = 3'd0;
        push_ev(r0 + 6,  K_PRESS,   0);
        push_ev(r0 + 26, K_LONG,    0);
        push_ev(r0 + 31, K_REPEAT,  0);
        push_ev(r0 + 36, K_RELEASE, 0);
        goto_cyc(r0 + 7);
        @(negedge clk);
        exp_sel = exp_sel + 3'd1;
        checks++;
        if (sel !== exp_sel) begin
            failures++;
            $display("FAIL midhold_sel_press actual=%0d required=%0d", sel, exp_sel);
        end
        goto_cyc(r0 + 30);
        btn_raw = 2'b11;
        goto_cyc(r0 + 45);
        @(negedge clk);
        exp_sel = exp_sel + 3'd1;
        checks++;
        if (sel !== exp_sel) begin
            failures++;
            $display("FAIL midhold_sel_final actual=%0d required=%0d", sel, exp_sel);
        end
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (i < exp_q.size()) ? exp_q[i] : -1;
            o = (i < obs_q.size()) ? obs_q[i] : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midhold_event%0d actual=%0d required=%0d (cyc*16+kind*4+btn)", i, o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_long_repeat();
        test_single_press();
        test_single_press();
        test_single_press();
        test_bounce();
        test_both();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
